// File: rtl/reg_xfer_sequencer_pkg.sv
// Shared definitions for the register-file transfer sequencer, the control unit and the register file.
// Holds the bus widths, the command opcodes and the sequencer state encodings.
package reg_xfer_sequencer_pkg;

  localparam int DATA_W     = 8;
  localparam int REG_ADDR_W = 4;

  typedef enum logic [1:0] {
    OP_RD  = 2'b00,
    OP_WR  = 2'b01,
    OP_MOV = 2'b10,
    OP_SWP = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_WR_A = 3'd3,
    ST_WR_B = 3'd4,
    ST_RESP = 3'd5
  } state_e;

  // Number of cycles from the accept edge to the first cycle showing rsp_valid.
  function automatic int unsigned op_latency(input op_e op);
    case (op)
      OP_RD:   op_latency = 32'd2;
      OP_WR:   op_latency = 32'd2;
      OP_MOV:  op_latency = 32'd3;
      OP_SWP:  op_latency = 32'd5;
      default: op_latency = 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/reg_xfer_sequencer_if.sv
// Command, response and register-file port bundle of the transfer sequencer.
// The slave modport is the sequencer's view; the master modport is the controller / register-file side.
interface reg_xfer_sequencer_if;
  import reg_xfer_sequencer_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [REG_ADDR_W-1:0] cmd_src;
  logic [REG_ADDR_W-1:0] cmd_dst;
  logic [DATA_W-1:0]     cmd_data;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_data;
  logic                  rf_dump;
  logic                  rf_load;
  logic [REG_ADDR_W-1:0] rf_regnum;
  logic [DATA_W-1:0]     rf_wdata;
  logic [DATA_W-1:0]     rf_rdata;
  logic                  busy;

  modport slave (
    input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_data, rsp_ready, rf_rdata,
    output cmd_ready, rsp_valid, rsp_data, rf_dump, rf_load, rf_regnum, rf_wdata, busy
  );

  modport master (
    output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_data, rsp_ready, rf_rdata,
    input  cmd_ready, rsp_valid, rsp_data, rf_dump, rf_load, rf_regnum, rf_wdata, busy
  );

endinterface

// File: rtl/reg_xfer_sequencer.sv
// Command-driven initiator for the 16x8 register file port: sequences dump/load strobes for
// read, write, move and swap, and returns the transferred value on a held response.
module reg_xfer_sequencer
  import reg_xfer_sequencer_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  reg_xfer_sequencer_if.slave  bus
);

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  logic [REG_ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [DATA_W-1:0]     data_q, data_d, tmp_a_q, tmp_a_d, tmp_b_q, tmp_b_d;
  logic                  cmd_ready_q, cmd_ready_d, busy_q, busy_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]     rsp_data_q, rsp_data_d;
  logic                  rf_dump_q, rf_dump_d, rf_load_q, rf_load_d;
  logic [REG_ADDR_W-1:0] rf_regnum_q, rf_regnum_d;
  logic [DATA_W-1:0]     rf_wdata_q, rf_wdata_d;
  logic                  accept_s;

  // Next state, command latch, capture registers and next-cycle output decode.
  // Outputs are decoded from the next state so each registered strobe lines up with its state.
  always_comb begin
    accept_s = bus.cmd_valid & cmd_ready_q;
    op_d     = op_q;
    src_d    = src_q;
    dst_d    = dst_q;
    data_d   = data_q;
    if (accept_s) begin
      op_d   = op_e'(bus.cmd_op);
      src_d  = bus.cmd_src;
      dst_d  = bus.cmd_dst;
      data_d = bus.cmd_data;
    end else begin
      op_d   = op_q;
    end
    tmp_a_d = (state_q == ST_RD_A) ? bus.rf_rdata : tmp_a_q;
    tmp_b_d = (state_q == ST_RD_B) ? bus.rf_rdata : tmp_b_q;

    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = (op_d == OP_WR) ? ST_WR_A : ST_RD_A;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_A: begin
        case (op_q)
          OP_SWP:  state_d = ST_RD_B;
          OP_MOV:  state_d = ST_WR_B;
          default: state_d = ST_RESP;
        endcase
      end
      ST_RD_B: state_d = ST_WR_A;
      ST_WR_A: state_d = (op_q == OP_SWP) ? ST_WR_B : ST_RESP;
      ST_WR_B: state_d = ST_RESP;
      ST_RESP: state_d = bus.rsp_ready ? ST_IDLE : ST_RESP;
      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = {DATA_W{1'b0}};
    rf_dump_d   = 1'b0;
    rf_load_d   = 1'b0;
    rf_regnum_d = {REG_ADDR_W{1'b0}};
    rf_wdata_d  = {DATA_W{1'b0}};
    case (state_d)
      ST_IDLE: cmd_ready_d = 1'b1;
      ST_RD_A: begin
        rf_dump_d   = 1'b1;
        rf_regnum_d = src_d;
      end
      ST_RD_B: begin
        rf_dump_d   = 1'b1;
        rf_regnum_d = dst_d;
      end
      ST_WR_A: begin
        rf_load_d   = 1'b1;
        rf_regnum_d = src_d;
        rf_wdata_d  = (op_d == OP_SWP) ? tmp_b_d : data_d;
      end
      ST_WR_B: begin
        rf_load_d   = 1'b1;
        rf_regnum_d = dst_d;
        rf_wdata_d  = tmp_a_d;
      end
      ST_RESP: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = (op_d == OP_WR) ? data_d : tmp_a_d;
      end
      default: cmd_ready_d = 1'b0;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State, latched command, capture registers and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_RD;
      src_q       <= {REG_ADDR_W{1'b0}};
      dst_q       <= {REG_ADDR_W{1'b0}};
      data_q      <= {DATA_W{1'b0}};
      tmp_a_q     <= {DATA_W{1'b0}};
      tmp_b_q     <= {DATA_W{1'b0}};
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= {DATA_W{1'b0}};
      rf_dump_q   <= 1'b0;
      rf_load_q   <= 1'b0;
      rf_regnum_q <= {REG_ADDR_W{1'b0}};
      rf_wdata_q  <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      data_q      <= data_d;
      tmp_a_q     <= tmp_a_d;
      tmp_b_q     <= tmp_b_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rf_dump_q   <= rf_dump_d;
      rf_load_q   <= rf_load_d;
      rf_regnum_q <= rf_regnum_d;
      rf_wdata_q  <= rf_wdata_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.busy      = busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rf_dump   = rf_dump_q;
  assign bus.rf_load   = rf_load_q;
  assign bus.rf_regnum = rf_regnum_q;
  assign bus.rf_wdata  = rf_wdata_q;

endmodule
